// File: rtl/ram_arbiter_2p.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// Each granted access takes IDLE -> ACCESS -> RESP, with a one-cycle ack in RESP.
module ram_arbiter_2p #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_a,
   input  logic              req_b,
   input  logic              we_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              ack_a,
   output logic              ack_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_in,
   output logic              ram_wr,
   input  logic [DATA_W-1:0] ram_out
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;   // 1 = B owns the transaction
   logic                last_q, last_d;     // 1 = B was served last
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                ram_wr_q, ram_wr_d;
   logic                ack_a_q, ack_a_d;
   logic                ack_b_q, ack_b_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
   logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
   logic                grant_b_c;

   // B wins when alone, or on a tie when A was served last
   assign grant_b_c = req_b && (!req_a || !last_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ram_wr_q  <= 1'b0;
         ack_a_q   <= 1'b0;
         ack_b_q   <= 1'b0;
         busy_q    <= 1'b0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ram_wr_q  <= ram_wr_d;
         ack_a_q   <= ack_a_d;
         ack_b_q   <= ack_b_d;
         busy_q    <= busy_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ram_wr_d  = 1'b0;
      ack_a_d   = 1'b0;
      ack_b_d   = 1'b0;
      busy_d    = 1'b0;
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;

      case (state_q)
         IDLE: begin
            if (req_a || req_b) begin
               state_d  = ACCESS;
               owner_d  = grant_b_c;
               we_d     = grant_b_c ? we_b    : we_a;
               addr_d   = grant_b_c ? addr_b  : addr_a;
               wdata_d  = grant_b_c ? wdata_b : wdata_a;
               ram_wr_d = grant_b_c ? we_b    : we_a;
               busy_d   = 1'b1;
            end
         end
         ACCESS: begin
            state_d = RESP;
            last_d  = owner_q;
            ack_a_d = !owner_q;
            ack_b_d = owner_q;
            busy_d  = 1'b1;
            if (!we_q) begin
               if (owner_q) rdata_b_d = ram_out;
               else         rdata_a_d = ram_out;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ack_a    = ack_a_q;
   assign ack_b    = ack_b_q;
   assign rdata_a  = rdata_a_q;
   assign rdata_b  = rdata_b_q;
   assign busy     = busy_q;
   assign ram_addr = addr_q;
   assign ram_in   = wdata_q;
   assign ram_wr   = ram_wr_q;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Self-checking bench for ram_arbiter_2p: table vectors, corner sequences and
// random traffic compared against a transaction-timing reference model.
module tb_ram_arbiter_2p;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
   logic [AW-1:0] addr_a = '0, addr_b = '0;
   logic [DW-1:0] wdata_a = '0, wdata_b = '0;
   logic          ack_a, ack_b, busy, ram_wr;
   logic [DW-1:0] rdata_a, rdata_b, ram_in, ram_out;
   logic [AW-1:0] ram_addr;

   logic [DW-1:0] mem [256] = '{default: '0};

   int n_checks = 0;
   int n_fail   = 0;

   ram_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
      .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
      .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
      .busy(busy), .ram_addr(ram_addr), .ram_in(ram_in), .ram_wr(ram_wr),
      .ram_out(ram_out)
   );

   always #5 clk = ~clk;

   // RAM: synchronous write, combinational read
   always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_in;
   assign ram_out = mem[ram_addr];

   // Reference model: a transaction granted at edge g acks after edge g+1,
   // and the next grant can happen no earlier than edge g+3.
   int            cyc, g;
   bit            m_owner, m_we, m_last;
   logic [AW-1:0] m_addr, m_ram_addr;
   logic [DW-1:0] m_wdata, m_ram_in, m_rda, m_rdb;
   logic [DW-1:0] shadow [256];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      cyc = 0; g = -100; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0;
      m_rda = '0; m_rdb = '0; m_ram_addr = '0; m_ram_in = '0;
   endtask

   task automatic model_edge();
      cyc++;
      if (cyc >= g + 3 && (req_a || req_b)) begin
         m_owner    = (req_a && req_b) ? !m_last : req_b;
         m_we       = m_owner ? we_b : we_a;
         m_addr     = m_owner ? addr_b : addr_a;
         m_wdata    = m_owner ? wdata_b : wdata_a;
         m_ram_addr = m_addr;
         m_ram_in   = m_wdata;
         g          = cyc;
      end else if (cyc == g + 1) begin
         if (m_we)         shadow[m_addr] = m_wdata;
         else if (m_owner) m_rdb = shadow[m_addr];
         else              m_rda = shadow[m_addr];
         m_last = m_owner;
      end
   endtask

   task automatic check_outputs();
      chk("m_ack_a",    DW'(ack_a),  DW'(cyc == g + 1 && !m_owner));
      chk("m_ack_b",    DW'(ack_b),  DW'(cyc == g + 1 && m_owner));
      chk("m_busy",     DW'(busy),   DW'(cyc == g || cyc == g + 1));
      chk("m_ram_wr",   DW'(ram_wr), DW'(cyc == g && m_we));
      chk("m_ram_addr", DW'(ram_addr), DW'(m_ram_addr));
      chk("m_ram_in",   ram_in,  m_ram_in);
      chk("m_rdata_a",  rdata_a, m_rda);
      chk("m_rdata_b",  rdata_b, m_rdb);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst ack_a",    DW'(ack_a), '0);
      chk("rst ack_b",    DW'(ack_b), '0);
      chk("rst busy",     DW'(busy), '0);
      chk("rst ram_wr",   DW'(ram_wr), '0);
      chk("rst rdata_a",  rdata_a, '0);
      chk("rst rdata_b",  rdata_b, '0);
      chk("rst ram_addr", DW'(ram_addr), '0);
      chk("rst ram_in",   ram_in, '0);
      model_reset();
      rst_n = 1'b1;
   endtask

   // One complete transaction from a single requester; returns the read data seen with ack
   task automatic txn(input bit side_b, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output logic [DW-1:0] rd);
      req_a = !side_b; req_b = side_b;
      we_a = we; we_b = we; addr_a = a; addr_b = a; wdata_a = d; wdata_b = d;
      tick();
      tick();
      rd = side_b ? rdata_b : rdata_a;
      chk("txn ack", DW'(side_b ? ack_b : ack_a), DW'(1'b1));
      req_a = 1'b0; req_b = 1'b0;
      tick();
   endtask

   typedef struct {
      logic          ra, rb, wa, wb;
      logic [AW-1:0] aa, ab;
      logic [DW-1:0] da, db;
      logic          win_b;
      logic          chk_rd;
      logic [DW-1:0] exp_rd;
   } vec_t;

   vec_t          vecs [7];
   logic [AW-1:0] qaddr [7];
   logic [DW-1:0] rd;
   bit            act_a, act_b;
   int            bc;

   initial begin
      for (int i = 0; i < 256; i++) shadow[i] = '0;
      vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 8'h21, 32'h11111111, 32'h22222222, 1'b1, 1'b0, 32'h0};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 8'h21, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h0};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h21, 32'h0, 32'h0, 1'b1, 1'b1, 32'h22222222};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h11111111};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h20, 32'h0, 32'h0, 1'b1, 1'b1, 32'h11111111};
      qaddr = '{8'h3F, 8'h40, 8'h7F, 8'h80, 8'hBF, 8'hC0, 8'hFF};

      #2;
      do_reset();

      // Table vectors: write/read, tie-breaking and read-back
      for (int i = 0; i < 7; i++) begin
         req_a = vecs[i].ra; req_b = vecs[i].rb; we_a = vecs[i].wa; we_b = vecs[i].wb;
         addr_a = vecs[i].aa; addr_b = vecs[i].ab; wdata_a = vecs[i].da; wdata_b = vecs[i].db;
         tick();
         chk("vec busy", DW'(busy), DW'(1'b1));
         tick();
         chk("vec ack_a", DW'(ack_a), DW'(!vecs[i].win_b));
         chk("vec ack_b", DW'(ack_b), DW'(vecs[i].win_b));
         if (vecs[i].chk_rd)
            chk("vec rdata", vecs[i].win_b ? rdata_b : rdata_a, vecs[i].exp_rd);
         req_a = 1'b0; req_b = 1'b0;
         tick();
      end

      // Contention from reset: A, B, A, B ... every 3 cycles
      do_reset();
      req_a = 1'b1; we_a = 1'b0; addr_a = 8'h10;
      req_b = 1'b1; we_b = 1'b0; addr_b = 8'hC3;
      for (int t = 1; t <= 12; t++) begin
         tick();
         chk("contend ack_a", DW'(ack_a), DW'(t % 6 == 2));
         chk("contend ack_b", DW'(ack_b), DW'(t % 6 == 5));
         chk("contend both",  DW'(ack_a & ack_b), '0);
      end
      req_a = 1'b0; req_b = 1'b0;
      tick(); tick();

      // Quadrant boundaries written and read back by B
      for (int i = 0; i < 7; i++) txn(1'b1, 1'b1, qaddr[i], DW'(qaddr[i]), rd);
      for (int i = 0; i < 7; i++) begin
         txn(1'b1, 1'b0, qaddr[i], '0, rd);
         chk("quad rdata_b", rd, DW'(qaddr[i]));
      end

      // Reset during the ACCESS cycle of a write
      txn(1'b0, 1'b1, 8'h22, 32'h5A5A5A5A, rd);
      req_a = 1'b1; we_a = 1'b1; addr_a = 8'h22; wdata_a = 32'hFFFF0000;
      tick();
      chk("abort ram_wr pre", DW'(ram_wr), DW'(1'b1));
      rst_n = 1'b0;
      #1;
      chk("abort ram_wr", DW'(ram_wr), '0);
      chk("abort busy",   DW'(busy), '0);
      req_a = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk("abort no ack", DW'(ack_a | ack_b), '0);
      end
      do_reset();
      tick(); tick();
      txn(1'b0, 1'b0, 8'h22, '0, rd);
      chk("abort prior data", rd, 32'h5A5A5A5A);

      // Request held for one cycle only
      bc = 0;
      req_a = 1'b1; we_a = 1'b0; addr_a = 8'h10;
      tick();
      bc += int'(busy);
      req_a = 1'b0;
      tick();
      bc += int'(busy);
      chk("drop ack_a",   DW'(ack_a), DW'(1'b1));
      chk("drop rdata_a", rdata_a, 32'hDEADBEEF);
      for (int k = 0; k < 3; k++) begin
         tick();
         bc += int'(busy);
      end
      chk("drop busy cycles", DW'(bc), DW'(2));

      // Random traffic on a small address window
      act_a = 1'b0; act_b = 1'b0;
      for (int t = 0; t < 600; t++) begin
         if (!act_a && $urandom_range(2) == 0) begin
            act_a = 1'b1; req_a = 1'b1; we_a = 1'($urandom_range(1));
            addr_a = AW'($urandom_range(15)); wdata_a = $urandom();
         end
         if (!act_b && $urandom_range(2) == 0) begin
            act_b = 1'b1; req_b = 1'b1; we_b = 1'($urandom_range(1));
            addr_b = AW'($urandom_range(15)); wdata_b = $urandom();
         end
         tick();
         if (ack_a) begin
            if ($urandom_range(1) == 1) begin
               we_a = 1'($urandom_range(1)); addr_a = AW'($urandom_range(15)); wdata_a = $urandom();
            end else begin
               act_a = 1'b0; req_a = 1'b0;
            end
         end
         if (ack_b) begin
            if ($urandom_range(1) == 1) begin
               we_b = 1'($urandom_range(1)); addr_b = AW'($urandom_range(15)); wdata_b = $urandom();
            end else begin
               act_b = 1'b0; req_b = 1'b0;
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_arbiter_2p.md
RAM_ARBITER_2P -- requirements
Module: ram_arbiter_2p

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, the RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, the RAM data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports req_a / req_b, input, 1, access request from requester A / B.
REQ-006 The block SHALL have ports we_a / we_b, input, 1, 1 = write, 0 = read.
REQ-007 The block SHALL have ports addr_a / addr_b, input, ADDR_W, word address.
REQ-008 The block SHALL have ports wdata_a / wdata_b, input, DATA_W, write data.
REQ-009 The block SHALL have ports ack_a / ack_b, output, 1, one-cycle completion pulse.
REQ-010 The block SHALL have ports rdata_a / rdata_b, output, DATA_W, read data, valid while the matching ack is high.
REQ-011 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-012 The block SHALL have ports ram_addr (ADDR_W), ram_in (DATA_W) and ram_wr (1), outputs driving the RAM addr, in and wr pins.
REQ-013 The block SHALL have port ram_out, input, DATA_W, the RAM read data (combinational read of ram_addr).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-015 In IDLE with no request, the FSM SHALL remain in IDLE.
REQ-016 In IDLE with at least one req high, it SHALL select a winner, register the winner's we/addr/wdata and an owner flag, and move to ACCESS.
REQ-017 Arbitration SHALL be round-robin: with a single requester, that requester wins; with both, the requester not served last wins.
REQ-018 The last-served pointer SHALL update only on entry to RESP.
REQ-019 In ACCESS (exactly one cycle), ram_addr/ram_in SHALL carry the registered values and ram_wr SHALL equal the registered we.
REQ-020 At the end of ACCESS, ram_out SHALL be captured into the owner's rdata register for reads; for writes, the owner's rdata SHALL be left unchanged.
REQ-021 In RESP (exactly one cycle), the owner's ack SHALL be high, the other ack low, and the FSM SHALL return to IDLE.
REQ-022 Latency SHALL be 2 cycles from the IDLE edge sampling req to ack high; peak throughput SHALL be one transaction per 3 cycles.
REQ-023 ram_wr SHALL be 0 in IDLE and RESP; ram_addr/ram_in SHALL hold their last values outside ACCESS.
REQ-024 Requesters SHALL hold req and fields stable until ack; inputs SHALL be ignored outside IDLE.
REQ-025 A req dropped after grant SHALL not abort the transaction: the ack pulse SHALL still be issued.
REQ-026 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-027 The ack and ram_wr outputs SHALL be registered; no output SHALL be combinational from req inputs.

Reset
REQ-028 While rst_n=0, the FSM SHALL be IDLE; ack_a, ack_b, busy and ram_wr SHALL be 0; rdata_a, rdata_b, ram_addr and ram_in SHALL be 0; the last-served pointer SHALL select B, so A wins the first tie.
REQ-029 Reset asserted mid-operation SHALL force ram_wr low immediately (asynchronously), and no ack SHALL be issued for the aborted transaction.

Verification
REQ-030 Write then read: A writes addr 0x10 data 0xDEADBEEF, then reads 0x10 -> first ack_a 2 cycles after req; second ack_a with rdata_a=0xDEADBEEF; ram_wr high exactly 1 cycle total.
REQ-031 Contention: req_a and req_b held high together from reset, B reading 0xC3 -> grants A, B, A, B...; ack_a and ack_b alternate every 3 cycles; ack_a and ack_b never high in the same cycle.
REQ-032 Quadrant boundaries: B writes 0x3F, 0x40, 0x7F, 0x80, 0xBF, 0xC0, 0xFF with data=addr, then reads each -> rdata_b equals the address written.
REQ-033 Reset mid-ACCESS of a write to 0x22 -> ram_wr drops in the same cycle, no ack; a subsequent read of 0x22 returns the prior contents.
REQ-034 Req drop: A asserts req for 1 cycle only -> ack_a still pulses 2 cycles later; busy high for exactly 2 cycles.
